// File: rtl/blood_class_arbiter.sv
// ============================================================================
// Module   : blood_class_arbiter
// Purpose  : Round-robin shared blood-type classifier with a valid/ready
//            response channel. Optional saturating statistics are built
//            when BLOOD_STATS_EN is defined; otherwise the counters read 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module blood_class_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [3*NUM_REQ-1:0]       blood_type_bus,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       rsp_class,
  output logic                       busy,
  output logic [CNT_W-1:0]           accept_count,
  output logic [CNT_W-1:0]           reject_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     idx_q, idx_d;
  logic [2:0]          type_q, type_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                rsp_class_q, rsp_class_d;

  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;

  function automatic logic classify(input logic [2:0] t);
    case (t)
      3'b000, 3'b001, 3'b101: classify = 1'b1;
      default:                classify = 1'b0;
    endcase
  endfunction

  // First active requester at or above rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin : p_pick
    int pos;
    pick_found = 1'b0;
    pick_idx   = '0;
    pos        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr_q) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!pick_found && req[pos]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(pos);
      end
    end
  end

  always_comb begin : p_fsm
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    type_d      = type_q;
    grant_d     = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_class_d = rsp_class_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          idx_d   = pick_idx;
          type_d  = blood_type_bus[3*int'(pick_idx) +: 3];
          state_d = EVAL;
        end
      end
      EVAL: begin
        rsp_class_d = classify(type_q);
        rsp_id_d    = idx_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      type_q      <= '0;
      grant_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_class_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      type_q      <= type_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_class_q <= rsp_class_d;
    end
  end

  assign grant     = grant_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_class = rsp_class_q;
  assign busy      = (state_q != IDLE);

`ifdef BLOOD_STATS_EN
  logic             rsp_done;
  logic [CNT_W-1:0] accept_count_q, accept_count_d;
  logic [CNT_W-1:0] reject_count_q, reject_count_d;

  assign rsp_done = (state_q == RESP) && rsp_valid_q && rsp_ready;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    accept_count_d = accept_count_q;
    reject_count_d = reject_count_q;
    if (rsp_done) begin
      if (rsp_class_q) begin
        if (accept_count_q != '1) accept_count_d = accept_count_q + CNT_W'(1);
      end else begin
        if (reject_count_q != '1) reject_count_d = reject_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_count_q <= '0;
      reject_count_q <= '0;
    end else begin
      accept_count_q <= accept_count_d;
      reject_count_q <= reject_count_d;
    end
  end

  assign accept_count = accept_count_q;
  assign reject_count = reject_count_q;
`else
  assign accept_count = {CNT_W{1'b0}};
  assign reject_count = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_blood_class_arbiter.sv
// ============================================================================
// Module   : tb_blood_class_arbiter
// Purpose  : Scoreboard bench for blood_class_arbiter (4-way, 2-bit counters)
//            plus a 3-way instance for the non-power-of-two case.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_blood_class_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] bus;
  logic        ready;
  logic [3:0]  grant;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic        rsp_class;
  logic        busy;
  logic [1:0]  acc;
  logic [1:0]  rej;

  logic [2:0]  req3;
  logic [8:0]  bus3;
  logic        ready3;
  logic [2:0]  grant3;
  logic        valid3;
  logic [1:0]  id3;
  logic        class3;
  logic        busy3;
  logic [7:0]  acc3;
  logic [7:0]  rej3;

  blood_class_arbiter #(.NUM_REQ(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .blood_type_bus(bus),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_ready(ready),
    .rsp_id(rsp_id), .rsp_class(rsp_class), .busy(busy),
    .accept_count(acc), .reject_count(rej)
  );

  blood_class_arbiter #(.NUM_REQ(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .blood_type_bus(bus3),
    .grant(grant3), .rsp_valid(valid3), .rsp_ready(ready3),
    .rsp_id(id3), .rsp_class(class3), .busy(busy3),
    .accept_count(acc3), .reject_count(rej3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic       cls;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_rr    = 0;
  int   m_acc   = 0;
  int   m_rej   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic cls_of(input logic [2:0] t);
    return (t == 3'd0) || (t == 3'd1) || (t == 3'd5);
  endfunction

  function automatic int stat(input int v);
`ifdef BLOOD_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // One full transaction: predict, drive, await grant, optional backpressure, handshake.
  task automatic run_txn(input logic [3:0] rq, input logic [11:0] types,
                         input int hold, input logic [3:0] rq_after);
    int   idx;
    int   waits;
    exp_t e;
    idx = -1;
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (m_rr + k) % 4;
      if (idx < 0 && rq[p]) idx = p;
    end
    e.id  = 2'(idx);
    e.cls = cls_of(types[3*idx +: 3]);
    sb_q.push_back(e);
    req   = rq;
    bus   = types;
    ready = (hold == 0);
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (grant == 4'd0 && waits < 20);
    check("grant_lat", waits, 1);
    check("grant", grant, 4'b0001 << idx);
    req = rq_after;
    @(negedge clk);
    check("grant_pulse", grant, 0);
    check("rsp_valid", rsp_valid, 1);
    check("busy", busy, 1);
    e = sb_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_id", rsp_id, e.id);
      check("hold_class", rsp_class, e.cls);
      check("hold_grant", grant, 0);
    end
    ready = 1'b1;
    check("rsp_id", rsp_id, e.id);
    check("rsp_class", rsp_class, e.cls);
    @(negedge clk);
    check("rsp_done", rsp_valid, 0);
    check("idle", busy, 0);
    if (e.cls) m_acc = (m_acc < 3) ? m_acc + 1 : 3;
    else       m_rej = (m_rej < 3) ? m_rej + 1 : 3;
    m_rr = (int'(e.id) + 1) % 4;
    check("accept_count", acc, stat(m_acc));
    check("reject_count", rej, stat(m_rej));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int waits;
    rst_n  = 1'b0;
    req    = '0;
    bus    = '0;
    ready  = 1'b0;
    req3   = '0;
    bus3   = '0;
    ready3 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_id", rsp_id, 0);
    check("rst_class", rsp_class, 0);
    check("rst_busy", busy, 0);
    check("rst_acc", acc, 0);
    check("rst_rej", rej, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(4'b0001, {3'b000, 3'b000, 3'b000, 3'b101}, 0, 4'b0000);
    run_txn(4'b0100, {3'b000, 3'b110, 3'b000, 3'b000}, 0, 4'b0000);

    // Fair rotation with everyone requesting; covers all eight type codes.
    for (int i = 0; i < 6; i++)
      run_txn(4'b1111, {3'b101, 3'b010, 3'b001, 3'b000}, 0, 4'b1111);
    for (int i = 0; i < 4; i++)
      run_txn(4'b1111, {3'b111, 3'b110, 3'b100, 3'b011}, 0, (i == 3) ? 4'b0000 : 4'b1111);

    // Backpressure while a second requester rises mid-transaction.
    run_txn(4'b0010, {3'b000, 3'b000, 3'b001, 3'b000}, 10, 4'b1000);
    run_txn(4'b1000, {3'b100, 3'b000, 3'b000, 3'b000}, 0, 4'b0000);
    run_txn(4'b0001, {3'b000, 3'b000, 3'b000, 3'b000}, 0, 4'b0000);

    // Abort a transaction in RESP with an asynchronous reset.
    req   = 4'b0100;
    bus   = {3'b000, 3'b101, 3'b000, 3'b000};
    ready = 1'b0;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (grant == 4'd0 && waits < 20);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_valid", rsp_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", rsp_valid, 0);
    check("arst_id", rsp_id, 0);
    check("arst_class", rsp_class, 0);
    check("arst_busy", busy, 0);
    check("arst_acc", acc, 0);
    check("arst_rej", rej, 0);
    m_rr  = 0;
    m_acc = 0;
    m_rej = 0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(4'b1111, {3'b000, 3'b000, 3'b000, 3'b001}, 0, 4'b0000);

    // Three-requester instance: rotation wraps 2 -> 0, index 3 never appears.
    req3   = 3'b111;
    bus3   = {3'b001, 3'b110, 3'b101};
    ready3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int e;
      e = i % 3;
      waits = 0;
      do begin
        @(negedge clk);
        waits++;
      end while (grant3 == 3'd0 && waits < 20);
      check("n3_grant_lat", waits, 1);
      check("n3_grant", grant3, 3'b001 << e);
      @(negedge clk);
      check("n3_valid", valid3, 1);
      check("n3_id", id3, e);
      check("n3_class", class3, (e == 1) ? 0 : 1);
      @(negedge clk);
      check("n3_done", valid3, 0);
    end
    req3 = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
